// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - MEM-stage to 16-bit SRAM controller, two half-word phases per 32-bit access.
// Optional one-entry read buffer enabled by defining SRAM_ACCESS_CTRL_RDBUF_EN.
module sram_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          is_write_q;
  logic [16:0]   tag_q;
  logic [31:0]   wdata_q;
  logic [31:0]   read_data_q;
  logic [17:0]   sram_addr_q;
  logic [15:0]   sram_dq_out_q;
  logic          sram_dq_oe_q;
  logic          sram_we_n_q;

  logic [31:0] eff_d;
  logic [16:0] tag_d;
  logic        req;
  logic        phase_end;
  logic        buf_hit;
  logic [31:0] buf_rdata;
  logic        unused_bits;

  assign eff_d       = address - BASE_ADDR;
  assign tag_d       = eff_d[18:2];
  assign req         = rd_en | wr_en;
  assign phase_end   = (cnt_q == CNT_LAST);
  assign unused_bits = ^{eff_d[31:19], eff_d[1:0]};

  assign ready       = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

`ifdef SRAM_ACCESS_CTRL_RDBUF_EN
  logic        buf_valid_q;
  logic [16:0] buf_tag_q;
  logic [31:0] buf_data_q;

  assign buf_hit   = rd_en && !wr_en && buf_valid_q && (buf_tag_q == tag_d);
  assign buf_rdata = buf_data_q;

  // A completed read (miss or hit) refreshes the buffer with the word just returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if ((state_q == S_IDLE) && wr_en && buf_valid_q && (buf_tag_q == tag_d)) begin
      buf_valid_q <= 1'b0;
    end else if ((state_q == S_DONE) && !is_write_q) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= tag_q;
      buf_data_q  <= read_data_q;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  // Bus outputs are registered one state ahead so they line up with LO/HI cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      is_write_q    <= 1'b0;
      tag_q         <= '0;
      wdata_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            is_write_q <= wr_en;
            tag_q      <= tag_d;
            wdata_q    <= write_data;
            cnt_q      <= '0;
            if (buf_hit) begin
              state_q     <= S_DONE;
              read_data_q <= buf_rdata;
            end else begin
              state_q       <= S_LO;
              sram_addr_q   <= {tag_d, 1'b0};
              sram_dq_out_q <= write_data[15:0];
              sram_dq_oe_q  <= wr_en;
              sram_we_n_q   <= !wr_en;
            end
          end
        end
        S_LO: begin
          if (phase_end) begin
            cnt_q         <= '0;
            state_q       <= S_HI;
            sram_addr_q   <= {tag_q, 1'b1};
            sram_dq_out_q <= wdata_q[31:16];
            if (!is_write_q) read_data_q[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_HI: begin
          if (phase_end) begin
            cnt_q        <= '0;
            state_q      <= S_DONE;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            if (!is_write_q) read_data_q[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - table-driven bench for sram_access_ctrl with a behavioural SRAM.
module tb_sram_access_ctrl;
  localparam int WAIT = 1;
  localparam int FULL_CYC = 2 * (WAIT + 1) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  sram_access_ctrl #(.WAIT_CYCLES(WAIT), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  int we_total = 0;
  assign sram_dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
      we_total <= we_total + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            output int rcyc, output logic [17:0] alo, output logic [17:0] ahi,
                            output logic [15:0] dlo, output logic [15:0] dhi, output int we,
                            output int achg, output logic [31:0] rdata);
    int we0;
    logic [17:0] prev;
    rcyc = -1; alo = '0; ahi = '0; dlo = '0; dhi = '0; achg = 0; rdata = '0;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = addr; write_data = wd;
    we0 = we_total;
    prev = sram_addr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sram_addr !== prev) achg++;
      prev = sram_addr;
      if (c == 1) begin alo = sram_addr; dlo = sram_dq_out; end
      if (c == WAIT + 2) begin ahi = sram_addr; dhi = sram_dq_out; end
      if (ready) begin
        rcyc = c;
        rdata = read_data;
        break;
      end
      @(posedge clk); #1;
    end
    we = we_total - we0;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [17:0] exp_alo;
    logic [17:0] exp_ahi;
    int          exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  int          rcyc, we, achg, wsnap;
  logic [17:0] alo, ahi;
  logic [15:0] dlo, dhi;
  logic [31:0] rdata;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    vecs[0] = '{0, 1, 32'd1028, 32'hDEAD_BEEF, 18'd2, 18'd3, 4, 32'hDEAD_BEEF};
    vecs[1] = '{1, 0, 32'd1028, 32'h0,         18'd2, 18'd3, 0, 32'hDEAD_BEEF};
    vecs[2] = '{1, 1, 32'd1024, 32'h1234_5678, 18'd0, 18'd1, 4, 32'h1234_5678};
    vecs[3] = '{1, 0, 32'd1024, 32'h0,         18'd0, 18'd1, 0, 32'h1234_5678};
    vecs[4] = '{0, 1, 32'd1040, 32'hA5A5_5A5A, 18'd8, 18'd9, 4, 32'hA5A5_5A5A};
    vecs[5] = '{1, 0, 32'd1043, 32'h0,         18'd8, 18'd9, 0, 32'hA5A5_5A5A};
    vecs[6] = '{0, 1, 32'd1020, 32'hCAFE_F00D, 18'h3FFFE, 18'h3FFFF, 4, 32'hCAFE_F00D};
    vecs[7] = '{1, 0, 32'd1020, 32'h0,         18'h3FFFE, 18'h3FFFF, 0, 32'hCAFE_F00D};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_we_n", {31'd0, sram_we_n}, 32'd1);
    check("reset_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    check("reset_sram_addr", {14'd0, sram_addr}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, rcyc, alo, ahi, dlo, dhi, we, achg, rdata);
      check($sformatf("v%0d_ready_cycle", i), rcyc, FULL_CYC);
      check($sformatf("v%0d_addr_lo", i), {14'd0, alo}, {14'd0, vecs[i].exp_alo});
      check($sformatf("v%0d_addr_hi", i), {14'd0, ahi}, {14'd0, vecs[i].exp_ahi});
      check($sformatf("v%0d_we_cycles", i), we, vecs[i].exp_we);
      if (vecs[i].wr) begin
        check($sformatf("v%0d_dq_lo", i), {16'd0, dlo}, {16'd0, vecs[i].exp_data[15:0]});
        check($sformatf("v%0d_dq_hi", i), {16'd0, dhi}, {16'd0, vecs[i].exp_data[31:16]});
        check($sformatf("v%0d_mem_lo", i), {16'd0, mem[vecs[i].exp_alo[7:0]]}, {16'd0, vecs[i].exp_data[15:0]});
        check($sformatf("v%0d_mem_hi", i), {16'd0, mem[vecs[i].exp_ahi[7:0]]}, {16'd0, vecs[i].exp_data[31:16]});
      end else begin
        check($sformatf("v%0d_read_data", i), rdata, vecs[i].exp_data);
      end
    end

    // Reset in the second LO cycle of a write aborts it.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1048; write_data = 32'h1111_2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    check("abort_pre_we_n", {31'd0, sram_we_n}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_read_data", read_data, 32'd0);
    wsnap = we_total;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort_no_strobes", we_total - wsnap, 0);

    // Repeated read of one word, then write and re-read.
    run_access(1, 0, 32'd1028, 32'h0, rcyc, alo, ahi, dlo, dhi, we, achg, rdata);
    check("rb1_ready_cycle", rcyc, FULL_CYC);
    check("rb1_read_data", rdata, 32'hDEAD_BEEF);
    run_access(1, 0, 32'd1028, 32'h0, rcyc, alo, ahi, dlo, dhi, we, achg, rdata);
`ifdef SRAM_ACCESS_CTRL_RDBUF_EN
    check("rb2_ready_cycle", rcyc, 1);
    check("rb2_addr_changes", achg, 0);
`else
    check("rb2_ready_cycle", rcyc, FULL_CYC);
`endif
    check("rb2_read_data", rdata, 32'hDEAD_BEEF);
    check("rb2_we_cycles", we, 0);
    run_access(0, 1, 32'd1028, 32'h0BAD_F00D, rcyc, alo, ahi, dlo, dhi, we, achg, rdata);
    check("rb3_ready_cycle", rcyc, FULL_CYC);
    run_access(1, 0, 32'd1028, 32'h0, rcyc, alo, ahi, dlo, dhi, we, achg, rdata);
    check("rb4_ready_cycle", rcyc, FULL_CYC);
    check("rb4_read_data", rdata, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
